// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns architectural HI/LO, runs MULT/MULTU/DIV/DIVU
// over a fixed latency and serves MTHI/MTLO writes and MFHI/MFLO reads.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDUO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic { S_IDLE, S_RUN } state_t;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } op_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt;
    logic [31:0]    pend_hi, pend_lo;
    logic           start, commit, is_mul;
    logic [31:0]    res_hi, res_lo;
    logic [63:0]    prod_s, prod_u;
    logic [31:0]    a_mag, b_mag, uq, ur, sq, sr;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start)  state_nx = S_RUN;
            S_RUN:  if (commit) state_nx = S_IDLE;
            default:            state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == S_RUN);
        start  = (state == S_IDLE) && (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
        commit = (state == S_RUN) && (cnt == '0);
        is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        MDUO   = '0;
        if (mdu_op == OP_MFHI)      MDUO = HI;
        else if (mdu_op == OP_MFLO) MDUO = LO;
    end

    // Signed divide is done on magnitudes so INT_MIN / -1 wraps to INT_MIN with zero remainder.
    always_comb begin
        prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u = {32'b0, A} * {32'b0, B};
        a_mag  = A[31] ? -A : A;
        b_mag  = B[31] ? -B : B;
        uq     = '0;
        ur     = '0;
        if (mdu_op == OP_DIV && B != '0) begin
            uq = a_mag / b_mag;
            ur = a_mag % b_mag;
        end else if (B != '0) begin
            uq = A / B;
            ur = A % B;
        end
        sq = (A[31] ^ B[31]) ? -uq : uq;
        sr = A[31] ? -ur : ur;
        res_hi = HI;
        res_lo = LO;
        case (mdu_op)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_DIV:   if (B != '0) begin res_hi = sr; res_lo = sq; end
            OP_DIVU:  if (B != '0) begin res_hi = ur; res_lo = uq; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= '0;
            LO      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            cnt     <= '0;
        end else if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        end else if (state == S_RUN) begin
            if (commit) begin
                HI <= pend_hi;
                LO <= pend_lo;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end else if (mdu_op == OP_MTHI) begin
            HI <= A;
        end else if (mdu_op == OP_MTLO) begin
            LO <= A;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: deadline-based reference model with per-cycle
// compare, directed literal cases and randomized op streams.
module tb_e_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HI, LO, MDUO;

    e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .mdu_op(mdu_op), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO), .MDUO(MDUO)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Reference model: committed HI/LO plus one pending result with an absolute commit edge.
    logic [31:0] m_hi = '0, m_lo = '0, m_phi = '0, m_plo = '0;
    bit          m_active = 1'b0;
    int          m_edge = 0;
    int          m_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit r);
        int ia, ib;
        longint sa, sb, q, rm, p;
        longint unsigned ua, ub, up;
        m_edge++;
        if (r) begin
            m_hi = '0; m_lo = '0; m_active = 1'b0;
        end else if (m_active) begin
            if (m_edge == m_done) begin
                m_hi = m_phi; m_lo = m_plo; m_active = 1'b0;
            end
        end else begin
            ia = a; ib = b; sa = ia; sb = ib;
            ua = {32'b0, a}; ub = {32'b0, b};
            m_phi = m_hi; m_plo = m_lo;
            case (op)
                MULT: begin
                    p = sa * sb; m_phi = p[63:32]; m_plo = p[31:0];
                    m_active = 1'b1; m_done = m_edge + MULT_N;
                end
                MULTU: begin
                    up = ua * ub; m_phi = up[63:32]; m_plo = up[31:0];
                    m_active = 1'b1; m_done = m_edge + MULT_N;
                end
                DIV: begin
                    if (b != 0) begin
                        q = sa / sb; rm = sa % sb;
                        m_plo = q[31:0]; m_phi = rm[31:0];
                    end
                    m_active = 1'b1; m_done = m_edge + DIV_N;
                end
                DIVU: begin
                    if (b != 0) begin
                        m_plo = a / b; m_phi = a % b;
                    end
                    m_active = 1'b1; m_done = m_edge + DIV_N;
                end
                MTHI: m_hi = a;
                MTLO: m_lo = a;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit r = 1'b0);
        mdu_op = op; A = a; B = b; reset = r;
        @(posedge clk);
        model_edge(op, a, b, r);
        #1;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_len);
        int n;
        step(op, a, b);
        n = busy ? 1 : 0;
        while (busy && n < 200) begin
            step(NONE, '0, '0);
            if (busy) n++;
        end
        check({name, "_busy_len"}, 32'(n), 32'(exp_len));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'b0, busy}, {31'b0, m_active});
            check("HI", HI, m_hi);
            check("LO", LO, m_lo);
            check("MDUO", MDUO, (mdu_op == MFHI) ? m_hi : (mdu_op == MFLO) ? m_lo : 32'h0);
        end
    end

    initial begin
        int n;
        step(NONE, '0, '0, 1'b1);
        step(NONE, '0, '0, 1'b1);
        chk_en = 1'b1;
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_HI", HI, 32'h0);
        check("rst_LO", LO, 32'h0);

        run_op("mult", MULT, 32'hFFFF_FFFE, 32'd3, MULT_N);
        check("mult_HI", HI, 32'hFFFF_FFFF);
        check("mult_LO", LO, 32'hFFFF_FFFA);
        run_op("multu", MULTU, 32'hFFFF_FFFE, 32'd3, MULT_N);
        check("multu_HI", HI, 32'h0000_0002);
        check("multu_LO", LO, 32'hFFFF_FFFA);

        run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, DIV_N);
        check("div_LO", LO, 32'hFFFF_FFFD);
        check("div_HI", HI, 32'hFFFF_FFFF);
        run_op("divu", DIVU, 32'd7, 32'd2, DIV_N);
        check("divu_LO", LO, 32'd3);
        check("divu_HI", HI, 32'd1);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N);
        check("div_ovf_LO", LO, 32'h8000_0000);
        check("div_ovf_HI", HI, 32'h0);

        step(MTHI, 32'h1234, '0);
        step(MTLO, 32'h5678, '0);
        run_op("divu0", DIVU, 32'd5, 32'd0, DIV_N);
        check("divu0_HI", HI, 32'h1234);
        check("divu0_LO", LO, 32'h5678);

        step(MULT, 32'd3, 32'd4);
        step(NONE, '0, '0);
        step(MTLO, 32'hAAAA, '0);
        mdu_op = MFLO; #1;
        check("mflo_busy", MDUO, 32'h5678);
        n = 0;
        while (busy && n < 50) begin
            step(MFLO, '0, '0);
            n++;
        end
        check("mul_ign_LO", LO, 32'd12);
        check("mul_ign_HI", HI, 32'd0);
        run_op("b2b", MULTU, 32'd6, 32'd7, MULT_N);
        check("b2b_LO", LO, 32'd42);

        step(DIV, 32'd100, 32'd7);
        step(NONE, '0, '0);
        step(NONE, '0, '0);
        step(NONE, '0, '0, 1'b1);
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_HI", HI, 32'h0);
        check("rst_mid_LO", LO, 32'h0);
        repeat (15) step(NONE, '0, '0);
        check("no_late_LO", LO, 32'h0);

        step(MTHI, 32'hDEAD_BEEF, '0);
        mdu_op = MFHI; #1;
        check("mfhi", MDUO, 32'hDEAD_BEEF);
        step(MFHI, '0, '0);
        mdu_op = 4'd12; #1;
        check("op12_MDUO", MDUO, 32'h0);
        step(4'd12, 32'h1111_1111, 32'h2222_2222);
        check("op12_HI", HI, 32'hDEAD_BEEF);

        repeat (1500) begin
            step(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 99) == 0));
        end
        repeat (12) step(NONE, '0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
